// File: rtl/bambu_slave_port_initiator.sv
// Drives single read/write commands onto one channel of a Bambu two-channel slave memory port.
// Latency: request 1 cycle after accept, response 1 cycle after DataRdy (or after TIMEOUT request cycles).
// Backpressure: cmd_ready low while a command is in flight; rsp_valid is a one-cycle pulse with no backpressure.
module bambu_slave_port_initiator #(
    parameter int CHANNEL = 0,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8,
    parameter int SIZE_W  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [SIZE_W-1:0]     cmd_size,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_error,
    output logic [1:0]            S_oe_ram,
    output logic [1:0]            S_we_ram,
    output logic [2*ADDR_W-1:0]   S_addr_ram,
    output logic [2*DATA_W-1:0]   S_Wdata_ram,
    output logic [2*SIZE_W-1:0]   S_data_ram_size,
    input  logic [2*DATA_W-1:0]   Sout_Rdata_ram,
    input  logic [1:0]            Sout_DataRdy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int CNT_W = $clog2(TIMEOUT);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              oe_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [SIZE_W-1:0] size_q;

    logic              size_ok;
    logic              dat_rdy;
    logic [DATA_W-1:0] rdata;
    logic              unused_ok;

    assign size_ok = (cmd_size != '0) && (int'(cmd_size) <= DATA_W);
    assign dat_rdy = Sout_DataRdy[CHANNEL];
    assign rdata   = Sout_Rdata_ram[CHANNEL*DATA_W +: DATA_W];
    // Only our channel's response slice matters; the rest is deliberately ignored.
    assign unused_ok = ^{Sout_Rdata_ram, Sout_DataRdy};

    // Request registers are zero outside REQ, so placing them on the slice keeps the other channel at 0.
    assign S_oe_ram        = 2'(oe_q) << CHANNEL;
    assign S_we_ram        = 2'(we_q) << CHANNEL;
    assign S_addr_ram      = {{ADDR_W{1'b0}}, addr_q}  << (CHANNEL*ADDR_W);
    assign S_Wdata_ram     = {{DATA_W{1'b0}}, wdata_q} << (CHANNEL*DATA_W);
    assign S_data_ram_size = {{SIZE_W{1'b0}}, size_q}  << (CHANNEL*SIZE_W);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_error <= 1'b0;
            oe_q      <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_error <= 1'b0;
                    rsp_data  <= '0;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (size_ok) begin
                            state   <= ST_REQ;
                            cnt     <= '0;
                            oe_q    <= ~cmd_write;
                            we_q    <= cmd_write;
                            addr_q  <= cmd_addr;
                            wdata_q <= cmd_wdata;
                            size_q  <= cmd_size;
                        end else begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    // DataRdy takes priority so a reply on the final timeout cycle is still a success.
                    if (dat_rdy || cnt == CNT_W'(TIMEOUT-1)) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_error <= ~dat_rdy;
                        rsp_data  <= (dat_rdy && oe_q) ? rdata : '0;
                        oe_q      <= 1'b0;
                        we_q      <= 1'b0;
                        addr_q    <= '0;
                        wdata_q   <= '0;
                        size_q    <= '0;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_error <= 1'b0;
                    rsp_data  <= '0;
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bambu_slave_port_initiator.sv
// Directed bench: channel-0 and channel-1 initiators against a hand-driven slave responder.
module tb_bambu_slave_port_initiator;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid0 = 1'b0;
    logic        cmd_valid1 = 1'b0;
    logic        cmd_write = 1'b0;
    logic [6:0]  cmd_addr = '0;
    logic [7:0]  cmd_wdata = '0;
    logic [3:0]  cmd_size = '0;
    logic [1:0]  dr = '0;
    logic [15:0] rdata = '0;

    logic        cmd_ready0, rsp_valid0, rsp_error0;
    logic [7:0]  rsp_data0;
    logic [1:0]  oe0, we0;
    logic [13:0] addr0;
    logic [15:0] wd0;
    logic [7:0]  sz0;

    logic        cmd_ready1, rsp_valid1, rsp_error1;
    logic [7:0]  rsp_data1;
    logic [1:0]  oe1, we1;
    logic [13:0] addr1;
    logic [15:0] wd1;
    logic [7:0]  sz1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    bambu_slave_port_initiator #(.CHANNEL(0), .TIMEOUT(16)) u_dut0 (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
        .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .rsp_error(rsp_error0),
        .S_oe_ram(oe0), .S_we_ram(we0), .S_addr_ram(addr0), .S_Wdata_ram(wd0),
        .S_data_ram_size(sz0), .Sout_Rdata_ram(rdata), .Sout_DataRdy(dr)
    );

    bambu_slave_port_initiator #(.CHANNEL(1), .TIMEOUT(16)) u_dut1 (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
        .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .rsp_error(rsp_error1),
        .S_oe_ram(oe1), .S_we_ram(we1), .S_addr_ram(addr1), .S_Wdata_ram(wd1),
        .S_data_ram_size(sz1), .Sout_Rdata_ram(rdata), .Sout_DataRdy(dr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Waits for cmd_ready on the selected DUT, presents the command for one cycle; returns in cycle 1.
    task automatic issue(input bit sel, input bit w, input logic [6:0] a, input logic [7:0] d,
                         input logic [3:0] s);
        for (int i = 0; i < 20 && !(sel ? cmd_ready1 : cmd_ready0); i++) step();
        check_eq("cmd_ready_wait", sel ? cmd_ready1 : cmd_ready0, 1);
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_size  = s;
        if (sel) cmd_valid1 = 1'b1;
        else     cmd_valid0 = 1'b1;
        step();
        cmd_valid0 = 1'b0;
        cmd_valid1 = 1'b0;
    endtask

    task automatic check_bus0_idle(input string tag);
        check_eq(tag, {oe0, we0, addr0, wd0, sz0}, 0);
    endtask

    initial begin
        int n;

        // Reset and idle
        repeat (3) step();
        check_eq("reset_ready", cmd_ready0, 0);
        check_eq("reset_rsp", {rsp_valid0, rsp_error0, rsp_data0}, 0);
        check_bus0_idle("reset_bus");
        reset = 1'b0;
        step();
        check_eq("post_reset_ready", cmd_ready0, 1);
        for (int i = 0; i < 5; i++) begin
            check_bus0_idle("idle_bus");
            check_eq("idle_rsp", {rsp_valid0, rsp_error0, rsp_data0}, 0);
            step();
        end

        // Write, DataRdy one cycle after we
        issue(0, 1, 7'h05, 8'hA5, 4'd8);
        check_eq("wr_we_c1", we0, 2'b01);
        check_eq("wr_addr", addr0, 14'h0005);
        check_eq("wr_wdata", wd0, 16'h00A5);
        check_eq("wr_size", sz0, 8'h08);
        check_eq("wr_oe", oe0, 2'b00);
        step();
        check_eq("wr_we_c2", we0, 2'b01);
        dr = 2'b01;
        step();
        dr = 2'b00;
        check_eq("wr_we_drop", we0, 2'b00);
        check_eq("wr_rsp", {rsp_valid0, rsp_error0, rsp_data0}, {1'b1, 1'b0, 8'h00});
        check_eq("wr_ready_k1", cmd_ready0, 0);
        step();
        check_eq("wr_rsp_pulse", rsp_valid0, 0);
        check_eq("wr_ready_k2", cmd_ready0, 1);

        // Read with 2-cycle responder delay
        issue(0, 0, 7'h10, 8'h00, 4'd8);
        n = 0;
        for (int i = 0; i < 2; i++) begin
            if (oe0 == 2'b01 && addr0 == 14'h0010) n++;
            step();
        end
        if (oe0 == 2'b01) n++;
        rdata = 16'hFF3C;
        dr = 2'b01;
        step();
        dr = 2'b00;
        rdata = 16'h0000;
        check_eq("rd_oe_cycles", n, 3);
        check_eq("rd_rsp", {oe0, rsp_valid0, rsp_error0, rsp_data0}, {2'b00, 1'b1, 1'b0, 8'h3C});

        // Timeout with no DataRdy
        issue(0, 0, 7'h20, 8'h00, 4'd4);
        n = 0;
        for (int i = 0; i < 40 && !rsp_valid0; i++) begin
            if (oe0 == 2'b01) n++;
            step();
        end
        check_eq("to_req_cycles", n, 16);
        check_eq("to_rsp", {oe0, rsp_valid0, rsp_error0, rsp_data0}, {2'b00, 1'b1, 1'b1, 8'h00});

        // Next command, DataRdy in the first request cycle
        issue(0, 1, 7'h7F, 8'h5A, 4'd1);
        check_eq("fast_we", {we0, addr0, sz0}, {2'b01, 14'h007F, 8'h01});
        dr = 2'b01;
        step();
        dr = 2'b00;
        check_eq("fast_rsp", {we0, rsp_valid0, rsp_error0}, {2'b00, 1'b1, 1'b0});

        // DataRdy on the last timeout cycle wins
        issue(0, 0, 7'h11, 8'h00, 4'd8);
        repeat (15) step();
        check_eq("last_oe", oe0, 2'b01);
        rdata = 16'h00C3;
        dr = 2'b01;
        step();
        dr = 2'b00;
        check_eq("last_rsp", {rsp_valid0, rsp_error0, rsp_data0}, {1'b1, 1'b0, 8'hC3});

        // Illegal sizes
        issue(0, 1, 7'h01, 8'h11, 4'd0);
        check_eq("size0_rsp", {rsp_valid0, rsp_error0, rsp_data0}, {1'b1, 1'b1, 8'h00});
        check_bus0_idle("size0_bus");
        issue(0, 0, 7'h01, 8'h11, 4'd9);
        check_eq("size9_rsp", {rsp_valid0, rsp_error0, rsp_data0}, {1'b1, 1'b1, 8'h00});
        check_bus0_idle("size9_bus");

        // Channel 1 read; DataRdy[0] must be ignored
        issue(1, 0, 7'h33, 8'h00, 4'd8);
        check_eq("ch1_oe", {oe1, we1}, {2'b10, 2'b00});
        check_eq("ch1_addr", addr1, 14'h1980);
        check_eq("ch1_size", sz1, 8'h80);
        rdata = 16'h0077;
        dr = 2'b01;
        step();
        check_eq("ch1_ignore_dr0", {oe1, rsp_valid1}, {2'b10, 1'b0});
        rdata = 16'h5A77;
        dr = 2'b10;
        step();
        dr = 2'b00;
        check_eq("ch1_rsp", {oe1, rsp_valid1, rsp_error1, rsp_data1}, {2'b00, 1'b1, 1'b0, 8'h5A});
        check_eq("ch0_quiet", {oe0, rsp_valid0}, 0);

        // Reset in the 3rd request cycle
        issue(0, 0, 7'h44, 8'h00, 4'd8);
        repeat (2) step();
        check_eq("rst_mid_oe", oe0, 2'b01);
        reset = 1'b1;
        step();
        check_bus0_idle("rst_mid_bus");
        check_eq("rst_mid_rsp", {rsp_valid0, cmd_ready0}, 0);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (rsp_valid0) n++;
        end
        check_eq("rst_no_rsp", n, 0);
        issue(0, 1, 7'h06, 8'h66, 4'd8);
        check_eq("rst_after_we", {we0, wd0}, {2'b01, 16'h0066});
        dr = 2'b01;
        step();
        dr = 2'b00;
        check_eq("rst_after_rsp", {rsp_valid0, rsp_error0}, {1'b1, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bambu_slave_port_initiator.md
# bambu_slave_port_initiator

Initiator for the two-channel slave memory port exposed by Bambu-generated `main` tops (`S_oe_ram`/`S_we_ram`/`S_addr_ram`/`S_Wdata_ram`/`S_data_ram_size` in, `Sout_Rdata_ram`/`Sout_DataRdy` out). It accepts single read/write commands from a simple valid/ready command port and drives one slave channel. It waits for the accelerator's `Sout_DataRdy`, then returns read data or a write acknowledge. It is used by testbenches and host bridges to preload accelerator-internal memories and read back results, in place of tying the slave port to zero.

## Interface
Parameters:
- `CHANNEL`, 0 — slave channel driven (0 or 1); the other channel's request bits stay 0.
- `ADDR_W`, 7 — per-channel address width; `S_addr_ram` is 2*ADDR_W.
- `DATA_W`, 8 — per-channel data width; `S_Wdata_ram`/`Sout_Rdata_ram` are 2*DATA_W.
- `SIZE_W`, 4 — per-channel size field width; `S_data_ram_size` is 2*SIZE_W.
- `TIMEOUT`, 16 — maximum request cycles without `Sout_DataRdy` before abort (≥2).

Ports:
- `clock` in 1 — single clock, all logic on posedge.
- `reset` in 1 — synchronous, active-high.
- `cmd_valid` in 1 — command present.
- `cmd_ready` out 1 — command accepted when `cmd_valid && cmd_ready`.
- `cmd_write` in 1 — 1 = write, 0 = read.
- `cmd_addr` in ADDR_W — target address.
- `cmd_wdata` in DATA_W — write data.
- `cmd_size` in SIZE_W — access size in bits (1..DATA_W).
- `rsp_valid` out 1 — one-cycle response pulse, no backpressure.
- `rsp_data` out DATA_W — read data (0 for writes/errors).
- `rsp_error` out 1 — qualifies `rsp_valid`: timeout or illegal size.
- `S_oe_ram` out 2, `S_we_ram` out 2, `S_addr_ram` out 2*ADDR_W, `S_Wdata_ram` out 2*DATA_W, `S_data_ram_size` out 2*SIZE_W — slave request, driven on slice `CHANNEL`.
- `Sout_Rdata_ram` in 2*DATA_W, `Sout_DataRdy` in 2 — slave response; only slice `CHANNEL` is used.

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE: `cmd_ready`=1. On accept with `cmd_size` in 1..DATA_W, register the command, go to REQ. On accept with illegal size (0 or >DATA_W), go to RESP with error; no bus activity.
- REQ: assert `S_oe_ram[CHANNEL]` (read) or `S_we_ram[CHANNEL]` (write), along with registered addr/wdata/size on the channel slice. Hold them stable until exit. The timeout counter increments each REQ cycle.
- Exit REQ when `Sout_DataRdy[CHANNEL]`=1: capture `Sout_Rdata_ram` slice (reads), then go to RESP without error.
- If the counter reaches TIMEOUT without DataRdy, go to RESP with `rsp_error`=1 and `rsp_data`=0.
- RESP: `rsp_valid`=1 for exactly one cycle; request outputs 0; then return to IDLE.
- `Sout_DataRdy` outside REQ, or on the unused channel, is ignored.
- All request outputs not on slice `CHANNEL` are constant 0.

## Timing
- Reset values: `cmd_ready`=0 during reset, then 1 from the first cycle after reset deasserts. All S_* outputs are 0; `rsp_valid`, `rsp_data`, and `rsp_error` are 0. FSM is IDLE and the counter is 0.
- All outputs are registered.
- Accept in cycle 0 → request visible in cycle 1.
- DataRdy is sampled in cycle k≥1 → request drops and `rsp_valid` is high in cycle k+1 → `cmd_ready` is high in cycle k+2.
- DataRdy in the same cycle as request first assertion counts.
- Timeout: request is high for exactly TIMEOUT cycles (1..TIMEOUT); `rsp_valid`+`rsp_error` follow in the next cycle.
- Illegal size: `rsp_valid`+`rsp_error` in cycle 1.
- DataRdy on the last timeout cycle wins: normal response, no error.
- Maximum throughput: one command per 3 cycles (accept, REQ≥1, RESP).
- Reset mid-REQ/RESP: all outputs are 0 in the next cycle. The pending command is dropped with no response.

## Test plan
- Reset, then idle for 5 cycles → all S_* and `rsp_*` outputs are 0. `cmd_ready`=1 from the first post-reset cycle.
- Write addr 0x05, data 0xA5, size 8, CHANNEL=0; responder raises DataRdy[0] 1 cycle after `we` → `S_we_ram`=2'b01, `S_addr_ram[6:0]`=0x05, `S_Wdata_ram[7:0]`=0xA5 for 2 cycles. `rsp_valid` follows with `rsp_error`=0 and `rsp_data`=0.
- Read addr 0x10 with a model returning 0x3C after a 2-cycle delay → `S_oe_ram[0]` high for 3 cycles. Then `rsp_valid` with `rsp_data`=0x3C.
- No DataRdy, TIMEOUT=16 → request high for exactly 16 cycles. Then `rsp_valid`=1, `rsp_error`=1, `rsp_data`=0; the next command is accepted normally.
- `cmd_size`=0 and `cmd_size`=9 → error response in cycle 1 with zero bus activity; CHANNEL=1 read → only bit 1 and the upper slices toggle; DataRdy[0] pulses are ignored.
- Reset asserted in the 3rd REQ cycle → request outputs are 0 next cycle, no `rsp_valid`. A following command completes normally.
